mux16_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the 16:1, 4-bit `mux16_1` datapath among 16 requesters. Each cycle it may grant one requester, drives the mux select (`s1` = upper 3 bits, `s0` = LSB), samples the mux output one cycle later, and presents the captured word with its source index on a valid/ready output port. It sits between the 16 producer lanes feeding `mux16_1` and a single downstream consumer.

---
 rtl/mux16_sched_pkg.sv | 17 +
 rtl/mux16_rr_scheduler_rr_pick16.sv | 29 ++
 rtl/mux16_rr_scheduler.sv | 103 ++++++++++
 tb/tb_mux16_rr_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux16_sched_pkg.sv
// Shared constants and FSM encodings for the round-robin mux16 scheduler.
package mux16_sched_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned S1_W  = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // One-hot decode of a lane index.
  function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return N_REQ'(1) << sel;
  endfunction

endpackage

// File: rtl/mux16_rr_scheduler_rr_pick16.sv
// Combinational round-robin picker: first set request at or above base, wrapping.
module rr_pick16
  import mux16_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] base,
  output logic             any,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [2*N_REQ-2:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // Doubling the vector turns the wrap-around search into a plain window select.
  always_comb begin
    dbl = {req[N_REQ-2:0], req};
    rot = dbl[base +: N_REQ];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    any    = |req;
    idx    = base + off;
    onehot = any ? sel_onehot(idx) : '0;
  end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Shares the 16:1 mux16_1 datapath among 16 lanes with round-robin grants and
// presents each sampled word on a valid/ready port.
module mux16_rr_scheduler
  import mux16_sched_pkg::*;
#(
  parameter int unsigned DW    = 4,
  parameter int unsigned N_REQ = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [S1_W-1:0]  s1,
  output logic             s0,
  input  logic [DW-1:0]    mux_y,
  output logic [DW-1:0]    out_data,
  output logic [SEL_W-1:0] out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] sel, sel_n;
  logic [N_REQ-1:0] grant_n;
  logic [DW-1:0]    out_data_n;
  logic [SEL_W-1:0] out_src_n;
  logic             out_valid_n;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  rr_pick16 u_pick (
    .req    (req),
    .base   (ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign s1 = sel[SEL_W-1:1];
  assign s0 = sel[0];

  // Next-state and register-update logic; a grant is held until its handshake.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    sel_n       = sel;
    grant_n     = grant;
    out_data_n  = out_data;
    out_src_n   = out_src;
    out_valid_n = out_valid;
    case (state)
      ST_IDLE: begin
        grant_n = '0;
        if (pick_any) begin
          sel_n   = pick_idx;
          grant_n = pick_onehot;
          state_n = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        out_data_n  = mux_y;
        out_src_n   = sel;
        out_valid_n = 1'b1;
        state_n     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          grant_n     = '0;
          ptr_n       = sel + SEL_W'(1);
          state_n     = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      sel       <= '0;
      grant     <= '0;
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      grant     <= grant_n;
      out_data  <= out_data_n;
      out_src   <= out_src_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Scoreboard bench for mux16_rr_scheduler with a mux16_1 whose input k carries value k.
module tb_mux16_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] grant;
  logic [2:0]  s1;
  logic        s0;
  logic [3:0]  mux_y;
  logic [3:0]  out_data;
  logic [3:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [3:0]  ptr_m;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mux16_1 with ik = k: the output is just the select value.
  assign mux_y = {s1, s0};

  mux16_rr_scheduler #(.DW(4), .N_REQ(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .s1        (s1),
    .s0        (s0),
    .mux_y     (mux_y),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [3:0] model_pick(input logic [15:0] r, input logic [3:0] p);
    logic [3:0] k;
    model_pick = p;
    for (int i = 15; i >= 0; i--) begin
      k = p + 4'(i);
      if (r[k]) model_pick = k;
    end
  endfunction

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_valid: out_valid=%b after 20 cycles, required 1", out_valid);
    end
  endtask

  // One full transaction with out_ready held high; returns the served lane and its cycle.
  task automatic run_txn(input logic [15:0] r, input string tag,
                         output logic [3:0] src_seen, output int t_valid);
    logic [3:0]  e;
    logic [15:0] eg;
    bit          ok;
    exp_q.push_back(model_pick(r, ptr_m));
    req       = r;
    out_ready = 1'b1;
    src_seen  = 4'hx;
    t_valid   = 0;
    wait_valid(ok);
    if (!ok) begin
      exp_q.delete();
    end else begin
      e        = exp_q.pop_front();
      eg       = 16'(1) << e;
      src_seen = out_src;
      t_valid  = cyc;
      vectors++;
      if (out_src !== e) begin
        miscompares++;
        $display("FAIL %s out_src: got %0d, required %0d", tag, out_src, e);
      end
      vectors++;
      if (out_data !== e) begin
        miscompares++;
        $display("FAIL %s out_data: got %0d, required %0d", tag, out_data, e);
      end
      vectors++;
      if (grant !== eg) begin
        miscompares++;
        $display("FAIL %s grant: got %h, required %h", tag, grant, eg);
      end
      vectors++;
      if ({s1, s0} !== e) begin
        miscompares++;
        $display("FAIL %s select: got %0d, required %0d", tag, {s1, s0}, e);
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || grant !== 16'h0) begin
        miscompares++;
        $display("FAIL %s handshake: got valid=%b grant=%h, required valid=0 grant=0000",
                 tag, out_valid, grant);
      end
      ptr_m = e + 4'd1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [3:0] src;
    int         t;
    rst_n     = 1'b0;
    req       = 16'hFFFF;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (grant !== 16'h0 || out_valid !== 1'b0 || {s1, s0} !== 4'h0 ||
        out_data !== 4'h0 || out_src !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_values: got grant=%h valid=%b sel=%0d data=%0d src=%0d, required all 0",
               grant, out_valid, {s1, s0}, out_data, out_src);
    end
    rst_n = 1'b1;
    ptr_m = '0;
    run_txn(16'hFFFF, "reset_first", src, t);
    vectors++;
    if (src !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_first_lane: got %0d, required 0", src);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] src;
    int         t, t_prev;
    run_txn(16'h0020, "b2b", src, t_prev);
    for (int i = 0; i < 4; i++) begin
      run_txn(16'h0020, "b2b", src, t);
      vectors++;
      if (src !== 4'd5 || t - t_prev !== 3) begin
        miscompares++;
        $display("FAIL b2b_rate: got lane %0d spacing %0d, required lane 5 spacing 3",
                 src, t - t_prev);
      end
      t_prev = t;
    end
  endtask

  task automatic test_rotation();
    logic [3:0] src;
    logic [3:0] want;
    int         t;
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      want = 4'(i % 16);
      run_txn(16'hFFFF, "rotation", src, t);
      vectors++;
      if (src !== want) begin
        miscompares++;
        $display("FAIL rotation_seq[%0d]: got %0d, required %0d", i, src, want);
      end
    end
  endtask

  task automatic test_pointer_skip();
    logic [3:0] src;
    int         t;
    run_txn(16'h0008, "skip_a", src, t);
    run_txn(16'h0009, "skip_b", src, t);
    vectors++;
    if (src !== 4'd0) begin
      miscompares++;
      $display("FAIL skip_wrap: got %0d, required 0", src);
    end
    run_txn(16'h0009, "skip_c", src, t);
    vectors++;
    if (src !== 4'd3) begin
      miscompares++;
      $display("FAIL skip_next: got %0d, required 3", src);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  e, d0, s0v, sel0;
    logic [15:0] g0;
    bit          ok;
    exp_q.push_back(model_pick(16'h0004, ptr_m));
    req       = 16'h0004;
    out_ready = 1'b0;
    wait_valid(ok);
    if (ok) begin
      e    = exp_q.pop_front();
      d0   = out_data;
      s0v  = out_src;
      g0   = grant;
      sel0 = {s1, s0};
      vectors++;
      if (s0v !== e || d0 !== e || g0 !== (16'(1) << e)) begin
        miscompares++;
        $display("FAIL bp_word: got src=%0d data=%0d grant=%h, required lane %0d", s0v, d0, g0, e);
      end
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== d0 || out_src !== s0v ||
            grant !== g0 || {s1, s0} !== sel0) begin
          miscompares++;
          $display("FAIL bp_hold[%0d]: got valid=%b data=%0d src=%0d grant=%h sel=%0d, required held",
                   i, out_valid, out_data, out_src, grant, {s1, s0});
        end
      end
      req       = '0;
      out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || grant !== 16'h0) begin
        miscompares++;
        $display("FAIL bp_release: got valid=%b grant=%h, required 0/0000", out_valid, grant);
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_single: got valid=%b, required 0", out_valid);
        end
      end
      ptr_m = e + 4'd1;
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic test_mid_op();
    logic [3:0] e, src;
    int         t;
    bit         ok;
    bit         seen;
    exp_q.push_back(model_pick(16'h0080, ptr_m));
    req       = 16'h0080;
    out_ready = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (grant !== 16'h0) seen = 1'b1;
    end
    req = '0;
    wait_valid(ok);
    if (ok) begin
      e = exp_q.pop_front();
      vectors++;
      if (out_src !== e || out_data !== e || e !== 4'd7) begin
        miscompares++;
        $display("FAIL drop_req: got src=%0d data=%0d, required 7", out_src, out_data);
      end
      out_ready = 1'b1;
      @(negedge clk);
      ptr_m = e + 4'd1;
    end else begin
      exp_q.delete();
    end

    // Reset pulse while a word sits in HOLD.
    req       = 16'h0002;
    out_ready = 1'b0;
    wait_valid(ok);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || grant !== 16'h0 || out_src !== 4'h0 ||
        out_data !== 4'h0 || {s1, s0} !== 4'h0) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%b grant=%h src=%0d data=%0d sel=%0d, required all 0",
               out_valid, grant, out_src, out_data, {s1, s0});
    end
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    ptr_m = '0;
    exp_q.delete();
    run_txn(16'hFFFF, "post_reset", src, t);
    vectors++;
    if (src !== 4'd0) begin
      miscompares++;
      $display("FAIL post_reset_ptr: got lane %0d, required 0", src);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    ptr_m     = '0;
    test_reset();
    test_back_to_back();
    test_rotation();
    test_pointer_skip();
    test_backpressure();
    test_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
